// File: rtl/li_arith_pkg.sv
// Shared types for the add/subtract pipeline.
// Width-dependent types are declared locally in the modules that use them.
package li_arith_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/li_fifo.sv
// Result buffer: a power-of-two circular FIFO with an occupancy count.
// The read data is the head entry and is only meaningful while o_empty is low.
module li_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_wdata,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_rdata,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Guard against overrun/underrun even if the caller does not.
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/li_arith_pipe.sv
// Add/subtract unit whose results (value, carry, overflow) are computed at
// acceptance and queued in a small FIFO for a ready/valid sink.
module li_arith_pipe
  import li_arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0]               in_a,
  input  logic [WIDTH-1:0]               in_b,
  input  op_e                            in_op,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [WIDTH-1:0]               out_result,
  output logic                           out_carry,
  output logic                           out_overflow,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int EW = WIDTH + 2;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic [EW-1:0]    w_wdata;
  logic [EW-1:0]    w_rdata;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_pop;

  // Subtraction is A + ~B + 1, so carry-out doubles as the no-borrow flag.
  assign w_b_eff = (in_op == OP_SUB) ? ~in_b : in_b;
  assign w_cin   = (in_op == OP_SUB);
  assign w_sum   = {1'b0, in_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
  assign w_ovf   = (in_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != in_a[WIDTH-1]);
  assign w_wdata = {w_ovf, w_sum};

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign w_accept  = in_valid & in_ready & ~rst;
  assign w_pop     = out_valid & out_ready & ~rst;

  li_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  // Head outputs read as zero whenever nothing is buffered.
  assign out_result   = out_valid ? w_rdata[WIDTH-1:0] : '0;
  assign out_carry    = out_valid & w_rdata[WIDTH];
  assign out_overflow = out_valid & w_rdata[WIDTH+1];

endmodule

// File: tb/tb_li_arith_pipe.sv
// Randomized and directed bench for li_arith_pipe against a queue-based model.
module tb_li_arith_pipe;
  import li_arith_pkg::*;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         ov;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  op_e           in_op = OP_ADD;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  out_result;
  logic          out_carry;
  logic          out_overflow;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pop   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  li_arith_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_op        (in_op),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned/signed integer arithmetic, not bit-level adder logic.
  function automatic exp_t ref_calc(input logic [W-1:0] a, input logic [W-1:0] b, input op_e op);
    exp_t        e;
    logic [63:0] ua, ub;
    longint      sa, sb, sv;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == OP_ADD) begin
      e.r = a + b;
      e.c = ((ua + ub) >> W) != 0;
      sv  = sa + sb;
    end else begin
      e.r = a - b;
      e.c = (ua >= ub);
      sv  = sa - sb;
    end
    e.ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    return e;
  endfunction

  task automatic check_outputs(input string tag);
    exp_t h;
    h = (q.size() > 0) ? q[0] : '0;
    chk({tag, ".count"},     64'(count),        64'(q.size()));
    chk({tag, ".in_ready"},  64'(in_ready),     64'(q.size() < D));
    chk({tag, ".out_valid"}, 64'(out_valid),    64'(q.size() != 0));
    chk({tag, ".result"},    64'(out_result),   64'(h.r));
    chk({tag, ".carry"},     64'(out_carry),    64'(h.c));
    chk({tag, ".ovf"},       64'(out_overflow), 64'(h.ov));
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
  task automatic step(input string tag, input logic v, input logic [W-1:0] a,
                      input logic [W-1:0] b, input op_e op, input logic ordy);
    logic acc, pp;
    in_valid = v; in_a = a; in_b = b; in_op = op; out_ready = ordy;
    @(posedge clk);
    acc = v && (q.size() < D);
    pp  = ordy && (q.size() > 0);
    if (pp) begin
      void'(q.pop_front());
      n_pop++;
    end
    if (acc) q.push_back(ref_calc(a, b, op));
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input logic ordy);
    step("idle", 1'b0, '0, '0, OP_ADD, ordy);
  endtask

  initial begin
    int pops0;
    #2;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    #1 check_outputs("post_reset");

    step("add5p3", 1'b1, 32'h5, 32'h3, OP_ADD, 1'b0);
    chk("add5p3.lit_res", 64'(out_result), 64'h8);
    chk("add5p3.lit_c",   64'(out_carry), 64'h0);
    chk("add5p3.lit_ov",  64'(out_overflow), 64'h0);
    idle(1'b1);

    step("addwrap", 1'b1, 32'hFFFF_FFFF, 32'h1, OP_ADD, 1'b0);
    chk("addwrap.lit_res", 64'(out_result), 64'h0);
    chk("addwrap.lit_c",   64'(out_carry), 64'h1);
    idle(1'b1);
    step("addovf", 1'b1, 32'h7FFF_FFFF, 32'h1, OP_ADD, 1'b0);
    chk("addovf.lit_res", 64'(out_result), 64'h8000_0000);
    chk("addovf.lit_ov",  64'(out_overflow), 64'h1);
    idle(1'b1);
    step("sub3m5", 1'b1, 32'h3, 32'h5, OP_SUB, 1'b0);
    chk("sub3m5.lit_res", 64'(out_result), 64'hFFFF_FFFE);
    chk("sub3m5.lit_c",   64'(out_carry), 64'h0);
    idle(1'b1);
    step("subovf", 1'b1, 32'h8000_0000, 32'h1, OP_SUB, 1'b0);
    chk("subovf.lit_res", 64'(out_result), 64'h7FFF_FFFF);
    chk("subovf.lit_ov",  64'(out_overflow), 64'h1);
    chk("subovf.lit_c",   64'(out_carry), 64'h1);
    idle(1'b1);

    // Fill to full with the sink stalled; the fifth offer must be refused.
    for (int i = 0; i < 5; i++)
      step("fill", 1'b1, 32'(100 + i), 32'(i), (i % 2) ? OP_SUB : OP_ADD, 1'b0);
    chk("fill.lit_count", 64'(count), 64'd4);
    chk("fill.lit_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    chk("drain.lit_count", 64'(count), 64'd0);

    // Streaming: one op per cycle, no bubbles, count stays at most one.
    pops0 = n_pop;
    for (int i = 0; i < 20; i++) begin
      step("stream", 1'b1, $urandom, $urandom, op_e'($urandom_range(0, 1)), 1'b1);
      chk("stream.count_le1", 64'(count <= 1), 64'd1);
    end
    idle(1'b1);
    chk("stream.pops", 64'(n_pop - pops0), 64'd20);

    // Asynchronous reset with three entries buffered.
    for (int i = 0; i < 3; i++)
      step("prefill", 1'b1, $urandom, $urandom, OP_ADD, 1'b0);
    #2 rst = 1'b1;
    #1;
    q.delete();
    check_outputs("async_rst");
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs("rst_held");
    rst = 1'b0;
    step("after_rst", 1'b1, 32'h1234, 32'h0034, OP_SUB, 1'b0);
    chk("after_rst.lit_res", 64'(out_result), 64'h1200);
    idle(1'b1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 1)), $urandom, $urandom,
           op_e'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 6; i++) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
